// File: rtl/shifter.sv
// rtl/shifter.sv - registered 1-bit shift unit (pass, shl, lsr, asr)
module shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] sout,
    output logic             sout_valid
);

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_SHL  = 2'b01,
        OP_LSR  = 2'b10,
        OP_ASR  = 2'b11
    } shift_op_e;

    logic [WIDTH-1:0] result;

    always_comb begin
        result = in;
        case (shift_op_e'(shift))
            OP_PASS: result = in;
            OP_SHL:  result = {in[WIDTH-2:0], 1'b0};
            OP_LSR:  result = {1'b0, in[WIDTH-1:1]};
            OP_ASR:  result = {in[WIDTH-1], in[WIDTH-1:1]};
            default: result = in;
        endcase
    end

    // sout holds across idle cycles; valid marks only the cycle after a capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout       <= '0;
            sout_valid <= 1'b0;
        end else begin
            sout_valid <= en;
            if (en) begin
                sout <= result;
            end
        end
    end

endmodule

// File: tb/tb_shifter.sv
// tb/tb_shifter.sv - randomized and directed checks of shifter against an arithmetic model
module tb_shifter;

    localparam int W = 16;
    localparam longint unsigned MOD  = 64'd1 << W;
    localparam longint unsigned HALF = 64'd1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] in = '0;
    logic [1:0]   shift = 2'b00;
    logic [W-1:0] sout;
    logic         sout_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_sout = '0;
    logic         exp_valid = 1'b0;

    shifter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in         (in),
        .shift      (shift),
        .sout       (sout),
        .sout_valid (sout_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Shift semantics expressed as multiply/divide on the unsigned value
    function automatic logic [W-1:0] ref_f(input logic [W-1:0] a, input logic [1:0] s);
        longint unsigned v;
        longint unsigned r;
        v = longint'(a);
        case (s)
            2'd0:    r = v;
            2'd1:    r = (v * 2) % MOD;
            2'd2:    r = v / 2;
            default: r = v / 2 + ((v >= HALF) ? HALF : 0);
        endcase
        return r[W-1:0];
    endfunction

    task automatic cycle(input logic e, input logic [W-1:0] d, input logic [1:0] s);
        en = e;
        in = d;
        shift = s;
        @(posedge clk);
        #1;
        if (e) exp_sout = ref_f(d, s);
        exp_valid = e;
        check("sout", 32'(sout), 32'(exp_sout));
        check("valid", 32'(sout_valid), 32'(exp_valid));
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   s;
        logic [W-1:0] expv;
    } dir_t;

    dir_t dir[10];

    initial begin
        dir[0] = '{16'h0002, 2'b00, 16'h0002};
        dir[1] = '{16'h0002, 2'b01, 16'h0004};
        dir[2] = '{16'h0003, 2'b01, 16'h0006};
        dir[3] = '{16'h8001, 2'b01, 16'h0002};
        dir[4] = '{16'h0002, 2'b10, 16'h0001};
        dir[5] = '{16'h000A, 2'b10, 16'h0005};
        dir[6] = '{16'h8000, 2'b10, 16'h4000};
        dir[7] = '{16'h8000, 2'b11, 16'hC000};
        dir[8] = '{16'h4000, 2'b11, 16'h2000};
        dir[9] = '{16'hFFFF, 2'b11, 16'hFFFF};

        // Reset held across an enabled edge: nothing captured
        en = 1'b1;
        in = 16'h5555;
        @(posedge clk);
        #1;
        check("rst_sout", 32'(sout), 32'h0);
        check("rst_valid", 32'(sout_valid), 32'h0);
        en = 1'b0;
        #3;
        rst_n = 1'b1;
        cycle(1'b0, 16'h1111, 2'b01);
        cycle(1'b0, 16'h2222, 2'b10);

        foreach (dir[i]) begin
            cycle(1'b1, dir[i].d, dir[i].s);
            check("dir", 32'(sout), 32'(dir[i].expv));
        end

        // Hold: inputs change while en is low
        cycle(1'b1, 16'h0002, 2'b01);
        cycle(1'b0, 16'h1234, 2'b01);
        in = 16'hBEEF;
        #2;
        check("hold_mid", 32'(sout), 32'h0004);
        cycle(1'b0, 16'h1234, 2'b11);
        check("hold", 32'(sout), 32'h0004);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 150; i++) begin
                cycle((i % 7 == 6) ? 1'b0 : 1'b1, W'($urandom), 2'($urandom_range(0, 3)));
            end
            // Asynchronous reset between edges, with a capture pending
            en = 1'b1;
            in = W'($urandom) | 16'h0100;
            #2;
            rst_n = 1'b0;
            #1;
            check("async_sout", 32'(sout), 32'h0);
            check("async_valid", 32'(sout_valid), 32'h0);
            exp_sout = '0;
            @(posedge clk);
            #1;
            check("in_rst_sout", 32'(sout), 32'h0);
            en = 1'b0;
            #2;
            rst_n = 1'b1;
            cycle(1'b0, 16'hA5A5, 2'b00);
            cycle(1'b0, 16'h5A5A, 2'b01);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
